// File: rtl/nibble_packer.sv
// Packs eight 4-bit nibbles into a 32-bit word behind a valid/ready output.
// Optional backspace input enabled by `define NIBBLE_PACKER_BACKSPACE_EN.
module nibble_packer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [3:0]  in_nib,
  output logic        in_ready,
  input  logic        clr,
`ifdef NIBBLE_PACKER_BACKSPACE_EN
  input  logic        del,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] cur_word,
  output logic [2:0]  ptr
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [2:0] START = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST  = MSB_FIRST ? 3'd0 : 3'd7;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  ptr_fwd, ptr_bck;
  logic        del_w;

`ifdef NIBBLE_PACKER_BACKSPACE_EN
  assign del_w = del;
`else
  assign del_w = 1'b0;
`endif

  assign ptr_fwd = MSB_FIRST ? ptr_q - 3'd1 : ptr_q + 3'd1;
  assign ptr_bck = MSB_FIRST ? ptr_q + 3'd1 : ptr_q - 3'd1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= FILL;
      word_q  <= '0;
      data_q  <= '0;
      ptr_q   <= START;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (clr) begin
      state_d = FILL;
      word_d  = '0;
      ptr_d   = START;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_valid) begin
            word_d[{ptr_q, 2'b00} +: 4] = in_nib;
            if (ptr_q == LAST) begin
              state_d = HOLD;
              data_d  = word_d;
              ptr_d   = START;
            end else begin
              ptr_d = ptr_fwd;
            end
          end else if (del_w && ptr_q != START) begin
            // step back and blank the slot just vacated
            word_d[{ptr_bck, 2'b00} +: 4] = 4'h0;
            ptr_d = ptr_bck;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = FILL;
            word_d  = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign cur_word  = word_q;
  assign ptr       = ptr_q;

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Assembles a 32-bit word from a stream of eight 4-bit nibbles, one nibble per handshake, into slots 0–7. Slot k occupies bits [4k+3:4k]. This is the write-side counterpart of the nibble-select display path, which reads nibble k of a 32-bit value for digit k. The block sits between hex-digit entry (switches/keypad debouncer) and the register or datapath consuming the 32-bit operand. It presents a valid/ready output for the completed word and exposes the live partial word and slot pointer for the scanning display.

## Interface
- `MSB_FIRST`, default 0. Fill-order selector:
  - 0: first nibble goes to slot 0 (bits [3:0]), and the pointer counts up.
  - 1: first nibble goes to slot 7 (bits [31:28]), and the pointer counts down.

- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rstn`  in  1  Reset, synchronous, active-low.
- `in_valid`  in  1  `in_nib` holds a nibble to accept.
- `in_nib`  in  4  Nibble value.
- `in_ready`  out  1  Block can accept a nibble this cycle.
- `clr`  in  1  Synchronous abort: discard the partial or held word.
- `out_valid`  out  1  `out_data` holds a completed word.
- `out_ready`  in  1  Consumer takes `out_data` this cycle.
- `out_data`  out  32  Completed word; stable while `out_valid`=1.
- `cur_word`  out  32  Live accumulator, including the partial word; intended for display.
- `ptr`  out  3  Slot the next accepted nibble is written to.

## Operation
- **States.**
  - FILL: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- **Accept.** A nibble is accepted when `in_valid` && `in_ready`. On accept, `cur_word[4*ptr +: 4]` <= `in_nib`; all other slots are unchanged.
- **Pointer advance (MSB_FIRST=0).** `ptr` increments after each accept. Accepting at `ptr`=7 completes the word.
- **Pointer advance (MSB_FIRST=1).** `ptr` decrements after each accept. Accepting at `ptr`=0 completes the word.
- **Completion.** The state goes FILL→HOLD and `out_data` <= the accumulator including the final nibble. `ptr` wraps to its start value: 0, or 7 if MSB_FIRST.
- **Release.** In HOLD, `out_ready`=1 causes HOLD→FILL and clears `cur_word` to 0. `out_data` holds its last value; it is don't-care while `out_valid`=0 but must not glitch while valid.
- **Ignored input in HOLD.** `in_valid` is ignored, because `in_ready`=0.
- **`clr` priority.** `clr`=1 overrides everything in the same cycle. The next state is FILL with `cur_word`=0, `ptr`=start and `out_valid`=0. A concurrent nibble accept or output handshake is discarded.
- **`rstn` priority.** `rstn`=0 has the highest priority, above `clr`.
- **Reset values.**
  - `in_ready`=1 (FILL).
  - `out_valid`=0.
  - `out_data`=0.
  - `cur_word`=0.
  - `ptr`=0 (MSB_FIRST=0) or 7 (MSB_FIRST=1).
- **Reset mid-operation.** Any partial or held word is lost; no output handshake completes in the reset cycle.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- An accept at edge N updates `cur_word` and `ptr` visibly in cycle N+1.
- Latency from the eighth accept edge to `out_valid`=1 is one cycle.
- The HOLD→FILL release takes effect on the edge where `out_valid`&&`out_ready`. `in_ready`=1 from the next cycle, so the minimum spacing between words is 8 accepts plus 1 HOLD cycle.
- Throughput in FILL is one nibble per cycle.

## Configuration
- Macro `NIBBLE_PACKER_BACKSPACE_EN`.
- **Defined:** adds the port `del  in  1`. In FILL, `del`=1 with no accept in the same cycle and at least one nibble held:
  - `ptr` steps back one slot (decrement, or increment if MSB_FIRST);
  - that slot in `cur_word` is cleared to 0.
- **`del` is ignored when:**
  - `ptr`=start (empty);
  - the state is HOLD;
  - a nibble is accepted in the same cycle (the accept wins);
  - `clr` is asserted (`clr` wins).
- **Undefined:** there is no `del` port, and behaviour is identical to `del` tied 0.

## Test plan
- **Basic fill.** Reset, MSB_FIRST=0, feed nibbles 1,2,…,8 on consecutive cycles -> `out_valid`=1 one cycle after the 8th accept, `out_data`=0x87654321, `in_ready`=0, `ptr`=0.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles with `in_valid`=1 and `in_nib`=F -> `out_data` stays 0x87654321 and no nibble is accepted. Then `out_ready`=1 -> next cycle `out_valid`=0, `cur_word`=0, `in_ready`=1.
- **Reverse fill.** MSB_FIRST=1, feed A,B,C,D,E,F,0,1 -> `out_data`=0xABCDEF01, `ptr` returns to 7.
- **Clear.** After 3 nibbles (5,6,7), assert `clr` together with `in_valid` (nibble 9) -> `cur_word`=0, `ptr`=0, nibble 9 discarded. A subsequent full fill of 0x11111111 completes normally.
- **Reset mid-HOLD.** While `out_valid`=1, assert `rstn`=0 for one cycle with `out_ready`=1 -> all outputs at their reset values, no word consumed.
- **Backspace (macro defined).**
  - Feed 3,4 then `del` -> `ptr`=1, `cur_word`=0x00000003.
  - Then `del` at `ptr`=0 twice -> second `del` ignored.
  - `del` together with an accept of nibble 6 -> the accept wins, and nibble 6 is written to slot 0.
